// File: rtl/result_sel_unit_pkg.sv
// rtl/result_sel_unit_pkg.sv - shared constants and state encoding for the result select unit
package result_sel_unit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_SRC = 6;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/result_sel_unit.sv
// rtl/result_sel_unit.sv - captures one of NUM_SRC result sources on request, waiting for its
// valid with a bounded timeout, and holds the captured value until the consumer takes it
module result_sel_unit
  import result_sel_unit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SEL_W-1:0]         req_sel,
  input  logic [NUM_SRC*WIDTH-1:0] src_data,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     err_sel,
  output logic                     err_timeout,
  input  logic                     err_clr
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_sel_q, err_sel_d;
  logic               err_to_q, err_to_d;

  logic [SEL_W-1:0]   mux_sel;
  logic               mux_in_range;
  logic               mux_valid;
  logic [WIDTH-1:0]   mux_word;

  // In WAIT the latched index drives the mux; otherwise the live request index does.
  always_comb begin
    mux_sel      = (state_q == ST_WAIT) ? sel_q : req_sel;
    mux_in_range = (int'(mux_sel) < NUM_SRC);
    mux_valid    = 1'b0;
    mux_word     = '0;
    if (mux_in_range) begin
      mux_valid = src_valid[mux_sel];
      mux_word  = src_data[int'(mux_sel)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    // Clear first so that a same-cycle error set below overrides it.
    err_sel_d = err_sel_q & ~err_clr;
    err_to_d  = err_to_q & ~err_clr;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          sel_d = req_sel;
          if (!mux_in_range) begin
            data_d    = '0;
            err_sel_d = 1'b1;
            state_d   = ST_HOLD;
          end else if (mux_valid) begin
            data_d  = mux_word;
            state_d = ST_HOLD;
          end else begin
            cnt_d   = '0;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mux_valid) begin
          data_d  = mux_word;
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          data_d   = '0;
          err_to_d = 1'b1;
          cnt_d    = CNT_DONE;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      err_sel_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      err_sel_q <= err_sel_d;
      err_to_q  <= err_to_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_data    = data_q;
  assign out_sel     = sel_q;
  assign err_sel     = err_sel_q;
  assign err_timeout = err_to_q;

endmodule

// File: tb/tb_result_sel_unit.sv
// tb/tb_result_sel_unit.sv - directed self-checking bench for result_sel_unit
module tb_result_sel_unit;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;
  localparam int TIMEOUT = 64;

  logic                     clk;
  logic                     reset_n;
  logic                     req_valid;
  logic                     req_ready;
  logic [SEL_W-1:0]         req_sel;
  logic [NUM_SRC*WIDTH-1:0] src_data;
  logic [NUM_SRC-1:0]       src_valid;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [SEL_W-1:0]         out_sel;
  logic                     err_sel;
  logic                     err_timeout;
  logic                     err_clr;

  int passed;
  int total;

  result_sel_unit #(
    .WIDTH  (WIDTH),
    .NUM_SRC(NUM_SRC),
    .SEL_W  (SEL_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sel    (req_sel),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .err_sel    (err_sel),
    .err_timeout(err_timeout),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_src(input int idx, input logic [31:0] val);
    src_data[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic load_known();
    for (int i = 0; i < NUM_SRC; i++) set_src(i, 32'h1000_0000 + i);
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_sel   = '0;
    src_data  = '0;
    src_valid = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    load_known();

    // Reset state
    tick();
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_err_sel", 32'(err_sel), 32'd0);
    check("rst_err_to", 32'(err_timeout), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    reset_n = 1'b1;
    tick();

    // Immediate capture, one-cycle latency
    set_src(3, 32'h0000_00AB);
    src_valid = 6'h3F;
    req_valid = 1'b1;
    req_sel   = 3'd3;
    tick();
    req_valid = 1'b0;
    check("imm_out_valid", 32'(out_valid), 32'd1);
    check("imm_out_data", out_data, 32'h0000_00AB);
    check("imm_out_sel", 32'(out_sel), 32'd3);
    check("imm_req_ready", 32'(req_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("imm_release_valid", 32'(out_valid), 32'd0);
    check("imm_release_ready", 32'(req_ready), 32'd1);

    // Out-of-range select
    req_valid = 1'b1;
    req_sel   = 3'd7;
    tick();
    req_valid = 1'b0;
    check("oor_out_valid", 32'(out_valid), 32'd1);
    check("oor_out_data", out_data, 32'd0);
    check("oor_out_sel", 32'(out_sel), 32'd7);
    check("oor_err_sel", 32'(err_sel), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    err_clr   = 1'b1;
    tick();
    err_clr = 1'b0;
    check("oor_err_clr", 32'(err_sel), 32'd0);

    // Clear and set in the same cycle: set wins
    err_clr   = 1'b1;
    req_valid = 1'b1;
    req_sel   = 3'd6;
    tick();
    err_clr   = 1'b0;
    req_valid = 1'b0;
    check("clr_vs_set_err_sel", 32'(err_sel), 32'd1);
    check("sel6_out_sel", 32'(out_sel), 32'd6);
    out_ready = 1'b1;
    err_clr   = 1'b1;
    tick();
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Wait for a late source valid
    src_valid = 6'h3D;
    req_valid = 1'b1;
    req_sel   = 3'd1;
    tick();
    req_valid = 1'b0;
    check("wait_in_wait_valid", 32'(out_valid), 32'd0);
    check("wait_in_wait_ready", 32'(req_ready), 32'd0);
    repeat (4) tick();
    check("wait_still_waiting", 32'(out_valid), 32'd0);
    set_src(1, 32'hDEAD_BEEF);
    src_valid = 6'h3F;
    tick();
    check("wait_out_valid", 32'(out_valid), 32'd1);
    check("wait_out_data", out_data, 32'hDEAD_BEEF);
    check("wait_out_sel", 32'(out_sel), 32'd1);
    check("wait_err_to", 32'(err_timeout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Timeout after exactly TIMEOUT wait cycles
    src_valid = 6'h3E;
    req_valid = 1'b1;
    req_sel   = 3'd0;
    tick();
    req_valid = 1'b0;
    repeat (TIMEOUT - 1) tick();
    check("to_not_yet_valid", 32'(out_valid), 32'd0);
    check("to_not_yet_err", 32'(err_timeout), 32'd0);
    tick();
    check("to_out_valid", 32'(out_valid), 32'd1);
    check("to_out_data", out_data, 32'd0);
    check("to_err_timeout", 32'(err_timeout), 32'd1);
    check("to_out_sel", 32'(out_sel), 32'd0);
    out_ready = 1'b1;
    err_clr   = 1'b1;
    tick();
    out_ready = 1'b0;
    err_clr   = 1'b0;
    check("to_err_cleared", 32'(err_timeout), 32'd0);

    // Hold stability while sources toggle and a new request is pending
    src_valid = 6'h3F;
    set_src(2, 32'h2222_2222);
    req_valid = 1'b1;
    req_sel   = 3'd2;
    tick();
    req_sel = 3'd4;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < NUM_SRC; j++) set_src(j, $urandom());
      src_valid = NUM_SRC'($urandom());
      tick();
      check("hold_out_data", out_data, 32'h2222_2222);
    end
    check("hold_out_sel", 32'(out_sel), 32'd2);
    check("hold_out_valid", 32'(out_valid), 32'd1);
    load_known();
    src_valid = 6'h3F;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_rel_ready", 32'(req_ready), 32'd1);
    check("hold_rel_valid", 32'(out_valid), 32'd0);
    check("hold_rel_data", out_data, 32'h2222_2222);
    tick();
    req_valid = 1'b0;
    check("next_req_valid", 32'(out_valid), 32'd1);
    check("next_req_sel", 32'(out_sel), 32'd4);
    check("next_req_data", out_data, 32'h1000_0004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset mid-WAIT
    src_valid = 6'h1F;
    req_valid = 1'b1;
    req_sel   = 3'd5;
    tick();
    req_valid = 1'b0;
    repeat (3) tick();
    check("prerst_in_wait", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_sel", 32'(out_sel), 32'd0);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    check("postrst_no_output", 32'(out_valid), 32'd0);
    set_src(5, 32'h5555_AAAA);
    src_valid = 6'h3F;
    req_valid = 1'b1;
    req_sel   = 3'd5;
    tick();
    req_valid = 1'b0;
    check("postrst_out_valid", 32'(out_valid), 32'd1);
    check("postrst_out_data", out_data, 32'h5555_AAAA);
    check("postrst_out_sel", 32'(out_sel), 32'd5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/result_sel_unit.md
RESULT_SEL_UNIT -- requirements
Module: result_sel_unit

Interface
REQ-001 Parameter WIDTH, default 32: data width of every source and of the output.
REQ-002 Parameter NUM_SRC, default 6: number of selectable sources (index 0..NUM_SRC-1).
REQ-003 Parameter SEL_W, default 3: select width; the module SHALL be legal for any NUM_SRC <= 2**SEL_W.
REQ-004 Parameter TIMEOUT, default 64: maximum wait cycles for a source to become valid.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-007 req_valid  in  1  request to capture a source.
REQ-008 req_ready  out  1  unit can accept a request.
REQ-009 req_sel  in  SEL_W  source index for the request.
REQ-010 src_data  in  NUM_SRC*WIDTH  flattened sources; source i occupies bits [i*WIDTH +: WIDTH].
REQ-011 src_valid  in  NUM_SRC  per-source data-valid (e.g. Hi/Lo from a multi-cycle mult/div).
REQ-012 out_valid  out  1  out_data holds a captured result.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 out_data  out  WIDTH  registered captured result.
REQ-015 out_sel  out  SEL_W  index that produced out_data.
REQ-016 err_sel  out  1  sticky: out-of-range select seen.
REQ-017 err_timeout  out  1  sticky: source not valid within TIMEOUT cycles.
REQ-018 err_clr  in  1  synchronous clear of both sticky flags.

Function
REQ-019 FSM states: IDLE, WAIT, HOLD; req_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in HOLD.
REQ-020 IDLE, req_valid=1, req_sel >= NUM_SRC: capture out_data=0, out_sel=req_sel, set err_sel, go HOLD.
REQ-021 IDLE, req_valid=1, in range, src_valid[req_sel]=1: capture that source, go HOLD; latency 1 cycle (out_valid on next edge).
REQ-022 IDLE, req_valid=1, in range, src_valid[req_sel]=0: latch sel, clear wait counter, go WAIT.
REQ-023 WAIT: capture first cycle src_valid[latched sel]=1 and go HOLD; otherwise increment counter.
REQ-024 WAIT: after TIMEOUT cycles without valid, capture out_data=0, set err_timeout, go HOLD.
REQ-025 Wait counter width SHALL be clog2(TIMEOUT+1) bits; it SHALL never wrap.
REQ-026 HOLD: out_data/out_sel stable until out_ready=1; on out_ready go IDLE (no same-cycle new accept).
REQ-027 Source changes after capture SHALL NOT affect out_data.
REQ-028 err_clr and a same-cycle error set: set wins.
REQ-029 req_valid outside IDLE is ignored; requester holds it until req_ready.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, out_valid=0, out_data=0, out_sel=0, err_sel=0, err_timeout=0, counter=0.
REQ-031 Reset in WAIT or HOLD SHALL abandon the operation with no output produced.

Structure
REQ-032 State encoding and the default WIDTH/NUM_SRC/TIMEOUT constants SHALL live in the shared CPU package.
REQ-033 Single module; the N-way source select SHALL be an indexed part-select, no sub-module.

Verification
REQ-034 src 3=0x0000_00AB, src_valid=all 1, req sel=3 -> next cycle out_valid=1, out_data=0x0000_00AB, out_sel=3.
REQ-035 req sel=7 (NUM_SRC=6) -> out_data=0, err_sel=1; err_clr pulse -> err_sel=0.
REQ-036 req sel=1, src_valid[1] rises 5 cycles later with 0xDEAD_BEEF -> out_valid 1 cycle after, out_data=0xDEAD_BEEF.
REQ-037 req sel=0, src_valid[0] held 0 -> after 64 WAIT cycles out_data=0, err_timeout=1.
REQ-038 HOLD with out_ready=0 for 10 cycles while sources toggle -> out_data constant; out_ready=1 -> IDLE, req_ready=1.
REQ-039 reset_n low mid-WAIT -> outputs zero same cycle; after release a new request completes normally.
